// File: rtl/cpu_pkg.sv
// Shared widths, the hard-wired zero register index and the forwarding source encoding.
// Pure declarations: no logic, no latency.
// No flow control of its own; imported by the operand stage and its interface.
package cpu_pkg;

  localparam int DATA_W   = 64;
  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 31;

  // Register index of XZR, sized to match register-index signals.
  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

  // Which source supplied an operand.
  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundles the ID-side inputs, the forwarding candidates and the ID/EX outputs of the operand stage.
// Wires only, no latency.
// Stalls are reported through stall; the stage itself has no ready input.
interface id_ex_operand_stage_if;
  import cpu_pkg::*;

  // ID stage inputs
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_Rn;
  logic [REG_AW-1:0] id_Rm;
  logic [REG_AW-1:0] id_Rd;
  logic              id_RegWrite;
  logic              id_MemRead;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  // Forwarding candidates from later stages
  logic [DATA_W-1:0] ex_Result;
  logic              mem_RegWrite;
  logic [REG_AW-1:0] mem_Rd;
  logic [DATA_W-1:0] mem_Result;
  logic              wb_RegWrite;
  logic [REG_AW-1:0] wb_Rd;
  logic [DATA_W-1:0] wb_Result;

  // Outputs of the stage
  logic              stall;
  logic              out_valid;
  logic [DATA_W-1:0] out_A;
  logic [DATA_W-1:0] out_B;
  logic [REG_AW-1:0] out_Rd;
  logic              out_RegWrite;
  logic              out_MemRead;
  fwd_sel_t          fwd_sel_a;
  fwd_sel_t          fwd_sel_b;

  // The operand stage itself
  modport slave (
    input  flush, id_valid, id_Rn, id_Rm, id_Rd, id_RegWrite, id_MemRead,
           ReadData1, ReadData2, ex_Result, mem_RegWrite, mem_Rd, mem_Result,
           wb_RegWrite, wb_Rd, wb_Result,
    output stall, out_valid, out_A, out_B, out_Rd, out_RegWrite, out_MemRead,
           fwd_sel_a, fwd_sel_b
  );

  // The surrounding pipeline driving the stage
  modport master (
    output flush, id_valid, id_Rn, id_Rm, id_Rd, id_RegWrite, id_MemRead,
           ReadData1, ReadData2, ex_Result, mem_RegWrite, mem_Rd, mem_Result,
           wb_RegWrite, wb_Rd, wb_Result,
    input  stall, out_valid, out_A, out_B, out_Rd, out_RegWrite, out_MemRead,
           fwd_sel_a, fwd_sel_b
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Picks one source operand: zero register, EX, MEM, (optionally WB), else regfile data.
// Combinational, zero latency.
// No flow control; the caller gates the EX candidate for loads. WB path only with WB_BYPASS_EN.
module operand_fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] operand,
  output fwd_sel_t          sel
);

`ifndef WB_BYPASS_EN
  // Without the bypass the regfile writes through, so the WB candidate is ignored.
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_result};
`endif

  // Youngest producer wins; XZR is never forwarded and always reads zero.
  always_comb begin
    sel     = FWD_RF;
    operand = rf_data;
    if (src == ZERO_IDX) begin
      sel     = FWD_ZERO;
      operand = '0;
    end else if (ex_we && (ex_rd == src) && (ex_rd != ZERO_IDX)) begin
      sel     = FWD_EX;
      operand = ex_result;
    end else if (mem_we && (mem_rd == src) && (mem_rd != ZERO_IDX)) begin
      sel     = FWD_MEM;
      operand = mem_result;
`ifdef WB_BYPASS_EN
    end else if (wb_we && (wb_rd == src) && (wb_rd != ZERO_IDX)) begin
      sel     = FWD_WB;
      operand = wb_result;
`endif
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register with EX/MEM(/WB when WB_BYPASS_EN is defined) forwarding and load-use detection.
// One cycle from ID inputs to out_*; a load-use inserts exactly one bubble.
// stall holds PC and IF/ID; flush squashes ID/EX and takes priority over stall.
module id_ex_operand_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  id_ex_operand_stage_if.slave  bus
);

  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  fwd_sel_t          sel_a;
  fwd_sel_t          sel_b;
  logic              ex_fwd_en;
  logic              load_use;

  logic              valid_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // A load's ex_Result is its address, not its data, so loads never forward from EX.
  assign ex_fwd_en = valid_q & reg_write_q & ~mem_read_q;

  operand_fwd_mux u_fwd_a (
    .src        (bus.id_Rn),
    .ex_we      (ex_fwd_en),
    .ex_rd      (rd_q),
    .ex_result  (bus.ex_Result),
    .mem_we     (bus.mem_RegWrite),
    .mem_rd     (bus.mem_Rd),
    .mem_result (bus.mem_Result),
    .wb_we      (bus.wb_RegWrite),
    .wb_rd      (bus.wb_Rd),
    .wb_result  (bus.wb_Result),
    .rf_data    (bus.ReadData1),
    .operand    (opnd_a),
    .sel        (sel_a)
  );

  operand_fwd_mux u_fwd_b (
    .src        (bus.id_Rm),
    .ex_we      (ex_fwd_en),
    .ex_rd      (rd_q),
    .ex_result  (bus.ex_Result),
    .mem_we     (bus.mem_RegWrite),
    .mem_rd     (bus.mem_Rd),
    .mem_result (bus.mem_Result),
    .wb_we      (bus.wb_RegWrite),
    .wb_rd      (bus.wb_Rd),
    .wb_result  (bus.wb_Result),
    .rf_data    (bus.ReadData2),
    .operand    (opnd_b),
    .sel        (sel_b)
  );

  // Load in EX whose destination is read by the instruction in ID: data not ready until MEM.
  assign load_use = bus.id_valid & valid_q & mem_read_q & (rd_q != ZERO_IDX) &
                    ((bus.id_Rn == rd_q) | (bus.id_Rm == rd_q));

  // ID/EX register: flush squashes, stall inserts a bubble, otherwise capture ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rd_q        <= ZERO_IDX;
      a_q         <= '0;
      b_q         <= '0;
    end else if (bus.flush || load_use) begin
      // Flush and bubble both kill the control bits; data fields simply hold.
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= bus.id_valid;
      reg_write_q <= bus.id_RegWrite & bus.id_valid;
      mem_read_q  <= bus.id_MemRead & bus.id_valid;
      rd_q        <= bus.id_Rd;
      a_q         <= opnd_a;
      b_q         <= opnd_b;
    end
  end

  assign bus.stall        = load_use;
  assign bus.out_valid    = valid_q;
  assign bus.out_A        = a_q;
  assign bus.out_B        = b_q;
  assign bus.out_Rd       = rd_q;
  assign bus.out_RegWrite = reg_write_q;
  assign bus.out_MemRead  = mem_read_q;
  assign bus.fwd_sel_a    = sel_a;
  assign bus.fwd_sel_b    = sel_b;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding priority, load-use, flush, WB bypass.
// Inputs change 1 time unit after posedge; outputs are sampled before the next posedge.
// Expected WB-bypass result follows the WB_BYPASS_EN setting of the build.
module tb_id_ex_operand_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  id_ex_operand_stage_if bus();

  id_ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush        = 1'b0;
    bus.id_valid     = 1'b0;
    bus.id_Rn        = '0;
    bus.id_Rm        = '0;
    bus.id_Rd        = '0;
    bus.id_RegWrite  = 1'b0;
    bus.id_MemRead   = 1'b0;
    bus.ReadData1    = '0;
    bus.ReadData2    = '0;
    bus.ex_Result    = '0;
    bus.mem_RegWrite = 1'b0;
    bus.mem_Rd       = '0;
    bus.mem_Result   = '0;
    bus.wb_RegWrite  = 1'b0;
    bus.wb_Rd        = '0;
    bus.wb_Result    = '0;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic we, input logic mr,
                          input logic [63:0] d1, input logic [63:0] d2);
    bus.id_valid    = v;
    bus.id_Rn       = rn;
    bus.id_Rm       = rm;
    bus.id_Rd       = rd;
    bus.id_RegWrite = we;
    bus.id_MemRead  = mr;
    bus.ReadData1   = d1;
    bus.ReadData2   = d2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 64'h5, 64'h6);
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.out_A !== 64'h0) begin n_err++; $display("FAIL reset out_A: got %h expected 0", bus.out_A); end
    n_vec++; if (bus.out_B !== 64'h0) begin n_err++; $display("FAIL reset out_B: got %h expected 0", bus.out_B); end
    n_vec++; if (bus.out_Rd !== 5'd31) begin n_err++; $display("FAIL reset out_Rd: got %0d expected 31", bus.out_Rd); end
    n_vec++; if (bus.out_RegWrite !== 1'b0) begin n_err++; $display("FAIL reset out_RegWrite: got %b expected 0", bus.out_RegWrite); end
    n_vec++; if (bus.out_MemRead !== 1'b0) begin n_err++; $display("FAIL reset out_MemRead: got %b expected 0", bus.out_MemRead); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset stall: got %b expected 0", bus.stall); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    idle();
    drive_id(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 64'h10, 64'h20);
    tick();
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b out_valid: got %b expected 1", bus.out_valid); end
    n_vec++; if (bus.out_Rd !== 5'd1) begin n_err++; $display("FAIL b2b out_Rd: got %0d expected 1", bus.out_Rd); end
    n_vec++; if (bus.out_A !== 64'h10) begin n_err++; $display("FAIL b2b first out_A: got %h expected 10", bus.out_A); end
    n_vec++; if (bus.out_B !== 64'h20) begin n_err++; $display("FAIL b2b first out_B: got %h expected 20", bus.out_B); end
    n_vec++; if (bus.out_RegWrite !== 1'b1) begin n_err++; $display("FAIL b2b out_RegWrite: got %b expected 1", bus.out_RegWrite); end
    bus.ex_Result = 64'hA0;
    drive_id(1'b1, 5'd1, 5'd4, 5'd6, 1'b1, 1'b0, 64'hDEAD, 64'h40);
    #1;
    n_vec++; if (bus.fwd_sel_a !== FWD_EX) begin n_err++; $display("FAIL b2b fwd_sel_a: got %0d expected %0d", bus.fwd_sel_a, FWD_EX); end
    n_vec++; if (bus.fwd_sel_b !== FWD_RF) begin n_err++; $display("FAIL b2b fwd_sel_b: got %0d expected %0d", bus.fwd_sel_b, FWD_RF); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL b2b stall: got %b expected 0", bus.stall); end
    tick();
    n_vec++; if (bus.out_A !== 64'hA0) begin n_err++; $display("FAIL b2b fwd out_A: got %h expected a0", bus.out_A); end
    n_vec++; if (bus.out_B !== 64'h40) begin n_err++; $display("FAIL b2b fwd out_B: got %h expected 40", bus.out_B); end
  endtask

  task automatic test_load_use();
    idle();
    drive_id(1'b1, 5'd3, 5'd31, 5'd2, 1'b1, 1'b1, 64'h100, 64'h999);
    tick();
    n_vec++; if (bus.out_MemRead !== 1'b1) begin n_err++; $display("FAIL lu load out_MemRead: got %b expected 1", bus.out_MemRead); end
    n_vec++; if (bus.out_B !== 64'h0) begin n_err++; $display("FAIL lu load out_B xzr: got %h expected 0", bus.out_B); end
    bus.ex_Result = 64'hBEEF;
    drive_id(1'b1, 5'd2, 5'd5, 5'd8, 1'b1, 1'b0, 64'hBAD, 64'h5);
    #1;
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL lu stall: got %b expected 1", bus.stall); end
    n_vec++; if (bus.fwd_sel_a !== FWD_RF) begin n_err++; $display("FAIL lu no ex fwd of load: got %0d expected %0d", bus.fwd_sel_a, FWD_RF); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL lu bubble out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.out_RegWrite !== 1'b0) begin n_err++; $display("FAIL lu bubble out_RegWrite: got %b expected 0", bus.out_RegWrite); end
    n_vec++; if (bus.out_MemRead !== 1'b0) begin n_err++; $display("FAIL lu bubble out_MemRead: got %b expected 0", bus.out_MemRead); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL lu stall after bubble: got %b expected 0", bus.stall); end
    bus.mem_RegWrite = 1'b1;
    bus.mem_Rd       = 5'd2;
    bus.mem_Result   = 64'h1234;
    #1;
    n_vec++; if (bus.fwd_sel_a !== FWD_MEM) begin n_err++; $display("FAIL lu fwd_sel_a: got %0d expected %0d", bus.fwd_sel_a, FWD_MEM); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL lu resume out_valid: got %b expected 1", bus.out_valid); end
    n_vec++; if (bus.out_A !== 64'h1234) begin n_err++; $display("FAIL lu mem out_A: got %h expected 1234", bus.out_A); end
    n_vec++; if (bus.out_B !== 64'h5) begin n_err++; $display("FAIL lu out_B: got %h expected 5", bus.out_B); end
    n_vec++; if (bus.out_Rd !== 5'd8) begin n_err++; $display("FAIL lu out_Rd: got %0d expected 8", bus.out_Rd); end
  endtask

  task automatic test_zero_reg();
    idle();
    bus.mem_RegWrite = 1'b1;
    bus.mem_Rd       = 5'd31;
    bus.mem_Result   = 64'hFF;
    drive_id(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 64'h77, 64'h88);
    #1;
    n_vec++; if (bus.fwd_sel_a !== FWD_ZERO) begin n_err++; $display("FAIL xzr fwd_sel_a: got %0d expected %0d", bus.fwd_sel_a, FWD_ZERO); end
    tick();
    n_vec++; if (bus.out_A !== 64'h0) begin n_err++; $display("FAIL xzr out_A: got %h expected 0", bus.out_A); end
    n_vec++; if (bus.out_B !== 64'h0) begin n_err++; $display("FAIL xzr out_B: got %h expected 0", bus.out_B); end
    // A load into XZR followed by a reader of XZR must not stall.
    drive_id(1'b1, 5'd31, 5'd0, 5'd4, 1'b1, 1'b0, 64'h1, 64'h2);
    #1;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL xzr load no stall: got %b expected 0", bus.stall); end
    tick();
  endtask

  task automatic test_priority();
    idle();
    drive_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 64'h1, 64'h2);
    tick();
    bus.ex_Result    = 64'h11;
    bus.mem_RegWrite = 1'b1;
    bus.mem_Rd       = 5'd5;
    bus.mem_Result   = 64'h22;
    drive_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 64'h33, 64'h44);
    tick();
    n_vec++; if (bus.out_A !== 64'h11) begin n_err++; $display("FAIL prio ex over mem out_A: got %h expected 11", bus.out_A); end
    n_vec++; if (bus.out_B !== 64'h11) begin n_err++; $display("FAIL prio ex over mem out_B: got %h expected 11", bus.out_B); end
    drive_id(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 64'h33, 64'h44);
    tick();
    n_vec++; if (bus.out_A !== 64'h22) begin n_err++; $display("FAIL prio mem only out_A: got %h expected 22", bus.out_A); end
  endtask

  task automatic test_flush();
    idle();
    drive_id(1'b1, 5'd1, 5'd1, 5'd9, 1'b1, 1'b1, 64'h1, 64'h1);
    tick();
    drive_id(1'b1, 5'd9, 5'd1, 5'd10, 1'b1, 1'b0, 64'h2, 64'h2);
    bus.flush = 1'b1;
    #1;
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL flush+stall stall: got %b expected 1", bus.stall); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush+stall out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.out_MemRead !== 1'b0) begin n_err++; $display("FAIL flush+stall out_MemRead: got %b expected 0", bus.out_MemRead); end
    drive_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 64'h3, 64'h4);
    bus.flush = 1'b1;
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.out_RegWrite !== 1'b0) begin n_err++; $display("FAIL flush out_RegWrite: got %b expected 0", bus.out_RegWrite); end
    bus.flush = 1'b0;
  endtask

  task automatic test_invalid();
    idle();
    drive_id(1'b0, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 64'h5, 64'h6);
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL invalid out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.out_RegWrite !== 1'b0) begin n_err++; $display("FAIL invalid out_RegWrite: got %b expected 0", bus.out_RegWrite); end
    n_vec++; if (bus.out_MemRead !== 1'b0) begin n_err++; $display("FAIL invalid out_MemRead: got %b expected 0", bus.out_MemRead); end
  endtask

  task automatic test_wb_bypass();
    logic [63:0] exp_b;
    fwd_sel_t    exp_sel;
`ifdef WB_BYPASS_EN
    exp_b   = 64'h55;
    exp_sel = FWD_WB;
`else
    exp_b   = 64'h0;
    exp_sel = FWD_RF;
`endif
    idle();
    bus.wb_RegWrite = 1'b1;
    bus.wb_Rd       = 5'd7;
    bus.wb_Result   = 64'h55;
    drive_id(1'b1, 5'd0, 5'd7, 5'd3, 1'b1, 1'b0, 64'h3, 64'h0);
    #1;
    n_vec++; if (bus.fwd_sel_b !== exp_sel) begin n_err++; $display("FAIL wb fwd_sel_b: got %0d expected %0d", bus.fwd_sel_b, exp_sel); end
    tick();
    n_vec++; if (bus.out_B !== exp_b) begin n_err++; $display("FAIL wb out_B: got %h expected %h", bus.out_B, exp_b); end
    n_vec++; if (bus.out_A !== 64'h3) begin n_err++; $display("FAIL wb out_A: got %h expected 3", bus.out_A); end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    drive_id(1'b1, 5'd1, 5'd1, 5'd4, 1'b1, 1'b1, 64'h1, 64'h1);
    tick();
    drive_id(1'b1, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 64'h2, 64'h2);
    #1;
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rst-stall pre stall: got %b expected 1", bus.stall); end
    reset = 1'b1;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst-stall out_valid: got %b expected 0", bus.out_valid); end
    n_vec++; if (bus.out_MemRead !== 1'b0) begin n_err++; $display("FAIL rst-stall out_MemRead: got %b expected 0", bus.out_MemRead); end
    n_vec++; if (bus.out_Rd !== 5'd31) begin n_err++; $display("FAIL rst-stall out_Rd: got %0d expected 31", bus.out_Rd); end
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst-stall stall: got %b expected 0", bus.stall); end
    reset = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_priority();
    test_flush();
    test_invalid();
    test_wb_bypass();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
